// File: rtl/rf_pkg.sv
// Shared definitions for the register-file read path: default widths,
// register count, occupancy encoding of the response buffer and the entry type.
package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 3;
    localparam int unsigned NUM_REGS      = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response buffer (address + data) with valid/ready on both sides.
// A push into a full buffer is allowed when a pop happens on the same edge.
module rsp_fifo2
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop_ready,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    occ_t                  occ;
    occ_t                  occ_next;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [ADDR_WIDTH-1:0] addr_mem [2];
    logic [DATA_WIDTH-1:0] data_mem [2];
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && push_ready;
    assign do_pop  = out_valid && pop_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ    <= OCC_EMPTY;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            occ <= occ_next;
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (do_push) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (do_push && !do_pop)      occ_next = OCC_FULL;
                else if (!do_push && do_pop) occ_next = OCC_EMPTY;
            end
            OCC_FULL:  if (do_pop && !do_push) occ_next = OCC_ONE;
            default:   occ_next = OCC_EMPTY;
        endcase
    end

    // Outputs read registered storage only, so they hold steady under backpressure.
    always_comb begin
        out_valid  = (occ != OCC_EMPTY);
        busy       = (occ != OCC_EMPTY);
        push_ready = (occ != OCC_FULL) || pop_ready;
        out_addr   = addr_mem[rd_ptr];
        out_data   = data_mem[rd_ptr];
    end

endmodule

// File: rtl/read_operation_ctrl.sv
// Read-side controller of the register file: selects the addressed register,
// forwards a same-cycle write, and returns data/address through rsp_fifo2.
module read_operation_ctrl
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] from_reg,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 wr_addr,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic                                  req_valid,
    input  logic [ADDR_WIDTH-1:0]                 req_addr,
    output logic                                  req_ready,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_WIDTH-1:0]                 rsp_data,
    output logic [ADDR_WIDTH-1:0]                 rsp_addr,
    output logic                                  busy
);

    localparam int unsigned REG_COUNT = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  fwd_hit;
    logic                  accept;

    always_comb begin
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[i] = from_reg[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The register file updates on the same edge, so a matching write wins.
    assign fwd_hit = wr_en && (wr_addr == req_addr);

    always_comb begin
        sel_data = regs[req_addr];
        if (fwd_hit) begin
            sel_data = wr_data;
        end
    end

    assign accept = req_valid && req_ready;

    rsp_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rsp_fifo2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (accept),
        .push_addr  (req_addr),
        .push_data  (sel_data),
        .push_ready (req_ready),
        .pop_ready  (rsp_ready),
        .out_valid  (rsp_valid),
        .out_addr   (rsp_addr),
        .out_data   (rsp_data),
        .busy       (busy)
    );

endmodule

// File: tb/tb_read_operation_ctrl.sv
// Bench for read_operation_ctrl: directed scenarios then random traffic,
// checked every cycle against a queue-based model of the response stream.
module tb_read_operation_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DW*NR-1:0]  from_reg;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              req_valid;
    logic [AW-1:0]     req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     rsp_addr;
    logic              busy;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic [DW-1:0] rf [NR];
    ent_t          q [$];
    bit            fresh;
    int            checks = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) from_reg[i*DW +: DW] = rf[i];
    end

    read_operation_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .from_reg  (from_reg),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, q.size() != 0});
        chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_addr", {29'd0, rsp_addr}, {29'd0, q[0].addr});
        end else if (fresh) begin
            chk("rsp_data_after_reset", rsp_data, '0);
            chk("rsp_addr_after_reset", {29'd0, rsp_addr}, '0);
        end
    endtask

    // One clock: inputs must already be driven; they stay put until return.
    task automatic cycle();
        bit   acc;
        bit   pop;
        ent_t e;
        @(negedge clk);
        if (reset_n) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, (q.size() < 2) || rsp_ready});
            acc = req_valid && ((q.size() < 2) || rsp_ready);
            pop = (q.size() != 0) && rsp_ready;
        end else begin
            chk("req_ready_in_reset", {31'd0, req_ready}, 32'd1);
            acc = 1'b0;
            pop = 1'b0;
        end
        e.addr = req_addr;
        e.data = (wr_en && wr_addr == req_addr) ? wr_data : rf[req_addr];
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            fresh = 1'b0;
        end
        if (wr_en) rf[wr_addr] = wr_data;
        #1;
        check_outputs();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        wr_en     = 1'b0;
    endtask

    task automatic randomize_inputs();
        req_valid = ($urandom_range(0, 3) != 0);
        req_addr  = AW'($urandom_range(0, NR - 1));
        wr_en     = ($urandom_range(0, 1) != 0);
        wr_addr   = AW'($urandom_range(0, NR - 1));
        wr_data   = $urandom;
        rsp_ready = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NR; i++) rf[i] = $urandom;
        randomize_inputs();
        fresh   = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_outputs();
        chk("req_ready_reset", {31'd0, req_ready}, 32'd1);

        // Reset held with random traffic, then released with nothing requested
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            cycle();
        end
        reset_n = 1'b1;
        idle();
        cycle();
        cycle();

        // Basic read with a one-cycle response pulse
        rf[5]     = 32'h0000_00A5;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 3'd5;
        cycle();
        chk("basic_data", rsp_data, 32'h0000_00A5);
        idle();
        cycle();

        // Forwarding hit, then write to another address
        rf[3]     = 32'h1111_1111;
        wr_en     = 1'b1;
        wr_addr   = 3'd3;
        wr_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 3'd3;
        cycle();
        chk("fwd_hit", rsp_data, 32'hDEAD_BEEF);
        rf[3]   = 32'h1111_1111;
        wr_addr = 3'd4;
        cycle();
        chk("fwd_miss", rsp_data, 32'h1111_1111);
        idle();
        cycle();

        // Fill under backpressure, hold a third request, then drain in order
        rf[1] = 32'h0000_0101;
        rf[2] = 32'h0000_0202;
        rf[3] = 32'h0000_0303;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 3'd1;
        cycle();
        req_addr = 3'd2;
        cycle();
        req_addr = 3'd3;
        cycle();
        cycle();
        chk("full_held_addr", {29'd0, rsp_addr}, 32'd1);
        rsp_ready = 1'b1;
        cycle();
        chk("drain_second", {29'd0, rsp_addr}, 32'd2);
        idle();
        cycle();
        chk("drain_third", {29'd0, rsp_addr}, 32'd3);
        cycle();
        cycle();

        // Snapshot: later write must not alter a buffered response
        rf[6]     = 32'h0000_600D;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 3'd6;
        cycle();
        req_valid = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 3'd6;
        wr_data   = 32'h0000_CAFE;
        cycle();
        chk("snapshot", rsp_data, 32'h0000_600D);
        idle();
        rsp_ready = 1'b1;
        cycle();
        cycle();

        // Asynchronous reset between edges with two responses buffered
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 3'd0;
        cycle();
        req_addr = 3'd7;
        cycle();
        idle();
        #3 reset_n = 1'b0;
        #1;
        q.delete();
        fresh = 1'b1;
        check_outputs();
        chk("req_ready_async_reset", {31'd0, req_ready}, 32'd1);
        cycle();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        cycle();
        req_valid = 1'b1;
        req_addr  = 3'd2;
        cycle();
        idle();
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            cycle();
        end
        idle();
        rsp_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/read_operation_ctrl.md
Name: read_operation_ctrl

Overview:
Read-side controller for the 8-entry register file, the read counterpart of the decoder-based write path. It accepts read requests over a valid/ready handshake and selects the addressed register from the flattened register-file contents. It forwards a same-cycle write to the read data, then returns the data and address through a 2-entry response buffer with its own valid/ready handshake. It sits between the register file and the ALU/bus master that consumes operands.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 3, register address width; register count is 2**ADDR_WIDTH (8)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
from_reg  input  DATA_WIDTH*8  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_en  input  1  write strobe of the register file (same signal that gates the decoded write enables)
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
req_valid  input  1  read request present
req_addr  input  ADDR_WIDTH  register to read
req_ready  output  1  request accepted when req_valid && req_ready
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready
rsp_data  output  DATA_WIDTH  read data
rsp_addr  output  ADDR_WIDTH  address the data belongs to
busy  output  1  high while any response is buffered

Behaviour:
- Reset (reset_n low, asynchronous): buffer empty, count=0, rd_ptr=wr_ptr=0. Outputs: rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0, req_ready=1. Reset asserted mid-transfer discards all buffered responses. No response may appear after reset deassertion without a new request.
- Accept: a request is accepted on a rising clk when req_valid && req_ready.
- Selected data at accept time:
  - If wr_en && wr_addr==req_addr, the data is wr_data (write-through forwarding; the register file updates on the same edge).
  - Otherwise, the data is from_reg slice req_addr.
  - The data is captured together with req_addr into buffer entry wr_ptr.
- Latency: 1 cycle. A request accepted at edge N gives rsp_valid=1 after edge N when the buffer was empty.
- Buffer: 2-entry FIFO, pointers 1 bit wide, wrapping 1->0.
  - rsp_valid = (count!=0).
  - rsp_data/rsp_addr come from entry rd_ptr and are registered storage, not combinational from from_reg.
  - Outputs stay stable while rsp_valid && !rsp_ready.
- req_ready = (count<2) || rsp_ready. When full and rsp_ready is high, a push and a pop happen on the same edge.
- Count update per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - Count never exceeds 2 and never goes below 0.
- Empty: rsp_ready is ignored and no pop occurs.
- Full with rsp_ready=0: req_ready=0. Requests are held by the requester and not sampled.
- busy = (count!=0). It is registered-equivalent, derived from the count register.
- Writes with no accepted request have no effect on buffered data. Already-buffered responses are NOT updated by later writes (snapshot semantics).
- No state machine beyond the occupancy count. States are EMPTY(0), ONE(1), FULL(2), with transitions as in the count update above.

Decomposition:
- Shared package rf_pkg: DATA_WIDTH and ADDR_WIDTH defaults, NUM_REGS=8, and the response entry type (addr + data).
- One sub-module: rsp_fifo2, the 2-entry FIFO (push/pop/count/pointers).
- The read mux and forwarding compare stay in read_operation_ctrl.

Test Plan:
1. Reset: hold reset_n=0 with random inputs -> rsp_valid=0, rsp_data=0, busy=0, req_ready=1. Release reset -> rsp_valid stays 0.
2. Basic read: reg5=0x0000_00A5, request addr 5 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0xA5, rsp_addr=5. One-cycle pulse.
3. Forwarding: reg3=0x1111_1111, same cycle wr_en=1, wr_addr=3, wr_data=0xDEAD_BEEF, request addr 3 -> rsp_data=0xDEAD_BEEF.
   - Same stimulus with wr_addr=4 -> rsp_data=0x1111_1111.
4. Backpressure/full: rsp_ready=0, issue reads of addr 1 and 2.
   - Expected: req_ready drops to 0 after the second accept, and a third request is held.
   - Then assert rsp_ready -> responses 1, 2, 3 arrive in order with no loss or duplication.
5. Snapshot: buffer a read of addr 6 with rsp_ready=0, then write 0xCAFE to reg6 -> buffered rsp_data keeps the old value.
6. Reset mid-operation: two entries buffered, pulse reset_n low asynchronously (between edges) -> rsp_valid falls immediately, busy=0. After release, only new requests produce responses.
